// File: rtl/traffic_lamp_monitor.sv
// Passive observer for the two-direction traffic-light controller: decodes phase, checks
// legality, measures dwell. Optional dwell checks are built with TLM_DWELL_CHECK_EN.
module traffic_lamp_monitor #(
    parameter int DW        = 8,
    parameter int MIN_YLW   = 3,
    parameter int MAX_DWELL = 200
) (
    input  logic          blif_clk_net,
    input  logic          blif_reset_net,
    input  logic          GRN1,
    input  logic          YLW1,
    input  logic          RED1,
    input  logic          GRN2,
    input  logic          YLW2,
    input  logic          RED2,
    input  logic          CLR,
    input  logic          ERR_ACK,
    output logic [2:0]    PHASE,
    output logic          PH_VALID,
    output logic [DW-1:0] DWELL,
    output logic          CYCLE_DONE,
    output logic [7:0]    CYCLE_CNT,
    output logic          ERR_ENC,
    output logic          ERR_CONFLICT,
    output logic          ERR_SEQ,
    output logic          ERR_YLW_SHORT,
    output logic          ERR_STUCK,
    output logic          ERR_ANY
);

    typedef enum logic [2:0] {
        ST_UNSYNC = 3'd0,
        ST_G1R2   = 3'd1,
        ST_Y1R2   = 3'd2,
        ST_R1G2   = 3'd3,
        ST_R1Y2   = 3'd4,
        ST_BAD    = 3'd7
    } phase_t;

    localparam bit CFG_OK = (MAX_DWELL < (2 ** DW)) && (MIN_YLW >= 0);

    if (!CFG_OK) begin : g_cfg_invalid
        $error("traffic_lamp_monitor: MAX_DWELL must be below 2**DW");
    end

    function automatic logic is_legal(input phase_t p);
        return (p == ST_G1R2) || (p == ST_Y1R2) || (p == ST_R1G2) || (p == ST_R1Y2);
    endfunction

    function automatic phase_t succ(input phase_t p);
        case (p)
            ST_G1R2: return ST_Y1R2;
            ST_Y1R2: return ST_R1G2;
            ST_R1G2: return ST_R1Y2;
            default: return ST_G1R2;
        endcase
    endfunction

    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // ---- input stage ----
    logic [5:0] s_lamp;
    logic       s_clr;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            s_lamp <= '0;
            s_clr  <= 1'b0;
        end else begin
            s_lamp <= {GRN1, YLW1, RED1, GRN2, YLW2, RED2};
            s_clr  <= CLR;
        end
    end

    // ---- pattern classification ----
    logic   g1, y1, r1, g2, y2, r2;
    logic   ok1, ok2;
    phase_t pat;
    logic   pat_enc, pat_con;

    assign {g1, y1, r1, g2, y2, r2} = s_lamp;
    assign ok1 = $onehot({g1, y1, r1});
    assign ok2 = $onehot({g2, y2, r2});

    always_comb begin
        pat     = ST_BAD;
        pat_enc = 1'b0;
        pat_con = 1'b0;
        if (!ok1 || !ok2)   pat_enc = 1'b1;
        else if (!r1 && !r2) pat_con = 1'b1;
        else if (r1 && r2)   pat_enc = 1'b1;
        else if (g1)         pat = ST_G1R2;
        else if (y1)         pat = ST_Y1R2;
        else if (g2)         pat = ST_R1G2;
        else                 pat = ST_R1Y2;
    end

    // ---- sequence FSM ----
    phase_t        state, state_nxt;
    logic          enc_p, con_p, seq_p, done_p;
    logic [DW-1:0] dwell_nxt;

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) state <= ST_UNSYNC;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        enc_p     = 1'b0;
        con_p     = 1'b0;
        seq_p     = 1'b0;
        done_p    = 1'b0;
        if (s_clr) begin
            state_nxt = ST_UNSYNC;
        end else begin
            state_nxt = pat;
            enc_p     = pat_enc;
            con_p     = pat_con;
            // Only a legal-to-legal jump is a sequence error; UNSYNC/BAD resynchronise.
            if (is_legal(state) && is_legal(pat) && (pat != state) && (pat != succ(state)))
                seq_p = 1'b1;
            if ((state == ST_R1Y2) && (pat == ST_G1R2))
                done_p = 1'b1;
        end
    end

    always_comb begin
        if (state_nxt == ST_UNSYNC)  dwell_nxt = '0;
        else if (state_nxt != state) dwell_nxt = {{(DW-1){1'b0}}, 1'b1};
        else                         dwell_nxt = sat_inc(DWELL);
    end

    // ---- registered outputs and sticky flags ----
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            DWELL        <= '0;
            CYCLE_DONE   <= 1'b0;
            CYCLE_CNT    <= '0;
            ERR_ENC      <= 1'b0;
            ERR_CONFLICT <= 1'b0;
            ERR_SEQ      <= 1'b0;
        end else begin
            DWELL        <= dwell_nxt;
            CYCLE_DONE   <= done_p;
            if (done_p) CYCLE_CNT <= CYCLE_CNT + 8'd1;
            ERR_ENC      <= enc_p | (ERR_ENC & ~ERR_ACK);
            ERR_CONFLICT <= con_p | (ERR_CONFLICT & ~ERR_ACK);
            ERR_SEQ      <= seq_p | (ERR_SEQ & ~ERR_ACK);
        end
    end

`ifdef TLM_DWELL_CHECK_EN
    logic ylw_p, stuck_p;

    // DWELL still holds the length of the phase being left; CLR exits are exempt.
    assign ylw_p   = !s_clr && ((state == ST_Y1R2) || (state == ST_R1Y2)) &&
                     (state_nxt != state) && (DWELL < DW'(MIN_YLW));
    assign stuck_p = is_legal(state_nxt) && (dwell_nxt == DW'(MAX_DWELL));

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            ERR_YLW_SHORT <= 1'b0;
            ERR_STUCK     <= 1'b0;
        end else begin
            ERR_YLW_SHORT <= ylw_p | (ERR_YLW_SHORT & ~ERR_ACK);
            ERR_STUCK     <= stuck_p | (ERR_STUCK & ~ERR_ACK);
        end
    end
`else
    assign ERR_YLW_SHORT = 1'b0;
    assign ERR_STUCK     = 1'b0;
`endif

    assign PHASE    = state;
    assign PH_VALID = is_legal(state);
    assign ERR_ANY  = ERR_ENC | ERR_CONFLICT | ERR_SEQ | ERR_YLW_SHORT | ERR_STUCK;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Randomised self-checking bench for traffic_lamp_monitor against a cycle-level rule model.
module tb_traffic_lamp_monitor;

    localparam int DW        = 8;
    localparam int MIN_YLW   = 3;
    localparam int MAX_DWELL = 200;
    localparam int DMAX      = (1 << DW) - 1;

    localparam logic [5:0] L_G1R2 = 6'b100_001;
    localparam logic [5:0] L_Y1R2 = 6'b010_001;
    localparam logic [5:0] L_R1G2 = 6'b001_100;
    localparam logic [5:0] L_R1Y2 = 6'b001_010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    lamps = '0;
    logic          clr = 1'b0;
    logic          ack = 1'b0;
    logic [2:0]    PHASE;
    logic          PH_VALID;
    logic [DW-1:0] DWELL;
    logic          CYCLE_DONE;
    logic [7:0]    CYCLE_CNT;
    logic          ERR_ENC, ERR_CONFLICT, ERR_SEQ, ERR_YLW_SHORT, ERR_STUCK, ERR_ANY;

    int total = 0;
    int bad   = 0;

    traffic_lamp_monitor #(.DW(DW), .MIN_YLW(MIN_YLW), .MAX_DWELL(MAX_DWELL)) dut (
        .blif_clk_net(clk), .blif_reset_net(rst_n),
        .GRN1(lamps[5]), .YLW1(lamps[4]), .RED1(lamps[3]),
        .GRN2(lamps[2]), .YLW2(lamps[1]), .RED2(lamps[0]),
        .CLR(clr), .ERR_ACK(ack),
        .PHASE(PHASE), .PH_VALID(PH_VALID), .DWELL(DWELL),
        .CYCLE_DONE(CYCLE_DONE), .CYCLE_CNT(CYCLE_CNT),
        .ERR_ENC(ERR_ENC), .ERR_CONFLICT(ERR_CONFLICT), .ERR_SEQ(ERR_SEQ),
        .ERR_YLW_SHORT(ERR_YLW_SHORT), .ERR_STUCK(ERR_STUCK), .ERR_ANY(ERR_ANY)
    );

    always #5 clk = ~clk;

    // Reference model state: what the monitor should show after each edge.
    logic [5:0] m_sl;
    logic       m_sc;
    int         m_ph, m_dw, m_cnt;
    logic       m_cd;
    logic [4:0] m_err;   // {enc, conflict, seq, ylw_short, stuck}

    function automatic bit legal(input int p);
        return (p >= 1) && (p <= 4);
    endfunction

    function automatic void classify(input logic [5:0] l, output int ph, output bit e, output bit c);
        int n1, n2;
        n1 = int'(l[5]) + int'(l[4]) + int'(l[3]);
        n2 = int'(l[2]) + int'(l[1]) + int'(l[0]);
        e = 0; c = 0; ph = 7;
        if (n1 != 1 || n2 != 1)  e = 1;
        else if (!l[3] && !l[0]) c = 1;
        else if (l[3] && l[0])   e = 1;
        else if (l[0])           ph = l[5] ? 1 : 2;
        else                     ph = l[2] ? 3 : 4;
    endfunction

    task automatic model_reset();
        m_sl = '0; m_sc = 0; m_ph = 0; m_dw = 0; m_cnt = 0; m_cd = 0; m_err = '0;
    endtask

    task automatic model_edge();
        int np, dwn;
        bit e, c, seq, ylw, stk, cd;
        e = 0; c = 0; seq = 0; ylw = 0; stk = 0; cd = 0; np = 0;
        if (!m_sc) begin
            classify(m_sl, np, e, c);
            seq = legal(m_ph) && legal(np) && np != m_ph && np != (m_ph % 4) + 1;
            cd  = (m_ph == 4) && (np == 1);
        end
        if (np == 0)         dwn = 0;
        else if (np != m_ph) dwn = 1;
        else                 dwn = (m_dw >= DMAX) ? DMAX : m_dw + 1;
`ifdef TLM_DWELL_CHECK_EN
        ylw = !m_sc && (m_ph == 2 || m_ph == 4) && np != m_ph && m_dw < MIN_YLW;
        stk = legal(np) && dwn == MAX_DWELL;
`endif
        m_err = {e, c, seq, ylw, stk} | (m_err & {5{~ack}});
        m_ph  = np;
        m_dw  = dwn;
        m_cd  = cd;
        m_cnt = (m_cnt + int'(cd)) % 256;
        m_sl  = lamps;
        m_sc  = clr;
    endtask

    task automatic step(input logic [5:0] l, input logic c, input logic a);
        lamps = l; clr = c; ack = a;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (PHASE !== 3'd0 || PH_VALID !== 1'b0) begin bad++; $display("FAIL reset_phase got=%0d/%0b want=0/0", PHASE, PH_VALID); end
        total++; if (DWELL !== '0 || CYCLE_DONE !== 1'b0) begin bad++; $display("FAIL reset_dwell got=%0d/%0b want=0/0", DWELL, CYCLE_DONE); end
        total++; if (CYCLE_CNT !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", CYCLE_CNT); end
        total++; if ({ERR_ENC, ERR_CONFLICT, ERR_SEQ, ERR_YLW_SHORT, ERR_STUCK, ERR_ANY} !== 6'b0) begin
            bad++; $display("FAIL reset_err got=%b want=000000", {ERR_ENC, ERR_CONFLICT, ERR_SEQ, ERR_YLW_SHORT, ERR_STUCK, ERR_ANY});
        end
        rst_n = 1;
    endtask

    task automatic test_sequence();
        logic [5:0] pat [5];
        int         len [5];
        int         peak [8];
        int         order [$];
        int         last, dones;
        pat = '{L_G1R2, L_Y1R2, L_R1G2, L_R1Y2, L_G1R2};
        len = '{5, 3, 5, 3, 3};
        for (int i = 0; i < 8; i++) peak[i] = 0;
        last = 0; dones = 0;
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < len[s]; k++) begin
                step(pat[s], 0, (s == 0 && k < 2));
                total++; if (PHASE !== 3'(m_ph) || DWELL !== DW'(m_dw)) begin
                    bad++; $display("FAIL seq_track got=%0d/%0d want=%0d/%0d", PHASE, DWELL, m_ph, m_dw);
                end
                if (int'(PHASE) != last && legal(int'(PHASE))) order.push_back(int'(PHASE));
                last = int'(PHASE);
                if (int'(DWELL) > peak[PHASE]) peak[PHASE] = int'(DWELL);
                if (CYCLE_DONE) dones++;
            end
        end
        total++; if (order.size() != 5 || order[0] != 1 || order[1] != 2 || order[2] != 3 || order[3] != 4 || order[4] != 1) begin
            bad++; $display("FAIL seq_order got_size=%0d want=1,2,3,4,1", order.size());
        end
        total++; if (peak[1] != 5 || peak[2] != 3 || peak[3] != 5 || peak[4] != 3) begin
            bad++; $display("FAIL seq_peaks got=%0d,%0d,%0d,%0d want=5,3,5,3", peak[1], peak[2], peak[3], peak[4]);
        end
        total++; if (dones != 1 || CYCLE_CNT !== 8'd1) begin bad++; $display("FAIL seq_done got=%0d/%0d want=1/1", dones, CYCLE_CNT); end
        total++; if (ERR_ANY !== 1'b0) begin bad++; $display("FAIL seq_err_any got=%b want=0", ERR_ANY); end
    endtask

    task automatic test_seq_err();
        step(L_R1G2, 0, 0);
        total++; if (ERR_SEQ !== 1'b0) begin bad++; $display("FAIL seqerr_early got=%b want=0", ERR_SEQ); end
        step(L_R1G2, 0, 0);
        total++; if (ERR_SEQ !== 1'b1 || PHASE !== 3'd3) begin bad++; $display("FAIL seqerr_set got=%b/%0d want=1/3", ERR_SEQ, PHASE); end
        step(L_R1G2, 0, 1);
        total++; if (ERR_SEQ !== 1'b0 || ERR_SEQ !== m_err[2]) begin bad++; $display("FAIL seqerr_ack got=%b want=0", ERR_SEQ); end
        ack = 0;
    endtask

    task automatic test_conflict();
        step(6'b100_100, 0, 0);
        step(L_G1R2, 0, 0);
        total++; if (PHASE !== 3'd7 || ERR_CONFLICT !== 1'b1) begin bad++; $display("FAIL conflict_set got=%0d/%b want=7/1", PHASE, ERR_CONFLICT); end
        step(L_G1R2, 0, 0);
        total++; if (PHASE !== 3'd1 || DWELL !== DW'(1) || ERR_SEQ !== 1'b0) begin
            bad++; $display("FAIL conflict_resync got=%0d/%0d/%b want=1/1/0", PHASE, DWELL, ERR_SEQ);
        end
        step(L_G1R2, 0, 1);
        total++; if (ERR_ANY !== 1'b0) begin bad++; $display("FAIL conflict_ack got=%b want=0", ERR_ANY); end
    endtask

    task automatic test_dwell();
        bit hit;
        step(L_Y1R2, 0, 0);
        step(L_Y1R2, 0, 0);
        step(L_R1G2, 0, 0);
        step(L_R1G2, 0, 0);
`ifdef TLM_DWELL_CHECK_EN
        total++; if (ERR_YLW_SHORT !== 1'b1) begin bad++; $display("FAIL ylw_short got=%b want=1", ERR_YLW_SHORT); end
        for (int k = 0; k < 3; k++) step(L_R1Y2, 0, 1);
        hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            step(L_G1R2, 0, (m_dw < 150));
            if (m_dw == 199) begin
                total++; if (ERR_STUCK !== 1'b0) begin bad++; $display("FAIL stuck_early got=%b want=0", ERR_STUCK); end
            end
            if (m_dw == 200) begin
                hit = 1;
                total++; if (ERR_STUCK !== 1'b1 || DWELL !== DW'(200)) begin
                    bad++; $display("FAIL stuck_set got=%b/%0d want=1/200", ERR_STUCK, DWELL);
                end
            end
        end
        if (!hit) begin total++; bad++; $display("FAIL stuck_timeout got=no_dwell_200 want=dwell_200"); end
`else
        total++; if (ERR_YLW_SHORT !== 1'b0 || ERR_STUCK !== 1'b0) begin
            bad++; $display("FAIL dwell_tied got=%b%b want=00", ERR_YLW_SHORT, ERR_STUCK);
        end
        for (int k = 0; k < 3; k++) step(L_R1Y2, 0, 1);
        for (int k = 0; k < 3; k++) step(L_G1R2, 0, 1);
`endif
    endtask

    task automatic test_clr();
        for (int k = 0; k < 4; k++) step(L_R1G2, 0, 1);
        step(L_R1G2, 0, 0);
        total++; if (PHASE !== 3'd3 || ERR_ANY !== 1'b0) begin bad++; $display("FAIL clr_pre got=%0d/%b want=3/0", PHASE, ERR_ANY); end
        step(L_R1G2, 1, 0);
        step(L_Y1R2, 0, 0);
        total++; if (PHASE !== 3'd0 || DWELL !== '0 || CYCLE_DONE !== 1'b0) begin
            bad++; $display("FAIL clr_unsync got=%0d/%0d want=0/0", PHASE, DWELL);
        end
        step(L_Y1R2, 0, 0);
        total++; if (PHASE !== 3'd2 || ERR_SEQ !== 1'b0 || DWELL !== DW'(1)) begin
            bad++; $display("FAIL clr_resync got=%0d/%b/%0d want=2/0/1", PHASE, ERR_SEQ, DWELL);
        end
    endtask

    task automatic test_random();
        logic [5:0] leg [4];
        logic [5:0] l;
        int cur, r, errs;
        leg = '{L_G1R2, L_Y1R2, L_R1G2, L_R1Y2};
        cur = 1; errs = 0;
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(99);
            if (r < 5)       l = 6'($urandom);
            else if (r < 10) l = leg[$urandom_range(3)];
            else begin
                if ($urandom_range(2) == 0) cur = (cur + 1) % 4;
                l = leg[cur];
            end
            step(l, ($urandom_range(99) < 3), ($urandom_range(99) < 10));
            total++;
            if (PHASE !== 3'(m_ph) || PH_VALID !== legal(m_ph) || DWELL !== DW'(m_dw) ||
                CYCLE_DONE !== m_cd || CYCLE_CNT !== 8'(m_cnt) ||
                {ERR_ENC, ERR_CONFLICT, ERR_SEQ, ERR_YLW_SHORT, ERR_STUCK} !== m_err || ERR_ANY !== |m_err) begin
                bad++; errs++;
                if (errs < 10)
                    $display("FAIL random_cycle%0d got=ph%0d dw%0d cd%b cnt%0d err%b want=ph%0d dw%0d cd%b cnt%0d err%b",
                             k, PHASE, DWELL, CYCLE_DONE, CYCLE_CNT,
                             {ERR_ENC, ERR_CONFLICT, ERR_SEQ, ERR_YLW_SHORT, ERR_STUCK},
                             m_ph, m_dw, m_cd, m_cnt, m_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) step(L_G1R2, 0, 0);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        total++; if ({PHASE, PH_VALID, DWELL, CYCLE_DONE, CYCLE_CNT} !== '0) begin
            bad++; $display("FAIL reset_mid_out got=ph%0d dw%0d cnt%0d want=0", PHASE, DWELL, CYCLE_CNT);
        end
        total++; if ({ERR_ENC, ERR_CONFLICT, ERR_SEQ, ERR_YLW_SHORT, ERR_STUCK, ERR_ANY} !== 6'b0) begin
            bad++; $display("FAIL reset_mid_err got=%b want=000000", {ERR_ENC, ERR_CONFLICT, ERR_SEQ, ERR_YLW_SHORT, ERR_STUCK, ERR_ANY});
        end
        rst_n = 1;
    endtask

    task automatic test_wrap();
        step(L_G1R2, 0, 1);
        step(L_G1R2, 0, 1);
        for (int i = 0; i < 256; i++) begin
            step(L_Y1R2, 0, 0);
            step(L_R1G2, 0, 0);
            step(L_R1Y2, 0, 0);
            step(L_G1R2, 0, 0);
            total++; if (CYCLE_CNT !== 8'(m_cnt)) begin bad++; $display("FAIL wrap_track got=%0d want=%0d", CYCLE_CNT, m_cnt); end
        end
        step(L_G1R2, 0, 0);
        step(L_G1R2, 0, 0);
        total++; if (CYCLE_CNT !== 8'd0 || PHASE !== 3'd1) begin bad++; $display("FAIL wrap_zero got=%0d/%0d want=0/1", CYCLE_CNT, PHASE); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequence();
        test_seq_err();
        test_conflict();
        test_dwell();
        test_clr();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
